// File: rtl/seqdet_rr_sched.sv
// Shared "101" Mealy detector, time-multiplexed over NCH serial channels by a
// round-robin grant; keeps per-channel context and saturating match counters.
module seqdet_rr_sched #(
    parameter int NCH   = 4,
    parameter int CW    = $clog2(NCH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   bit_valid,
    input  logic [NCH-1:0]   bit_in,
    output logic [NCH-1:0]   bit_ready,
    output logic [NCH-1:0]   det_out,
    output logic             match_valid,
    output logic [CW-1:0]    match_ch,
    input  logic             cnt_clr,
    input  logic [CW-1:0]    rd_ch,
    output logic [CNT_W-1:0] rd_cnt
);

    typedef enum logic [1:0] {
        S0    = 2'b00,
        S1    = 2'b01,
        S2    = 2'b10,
        S_ILL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Returns {match, next_state}; matching from S2 restarts at S0 (non-overlapping).
    function automatic logic [2:0] mealy_step(input state_t st, input logic b);
        case (st)
            S0:      mealy_step = b ? {1'b0, S1} : {1'b0, S0};
            S1:      mealy_step = b ? {1'b0, S1} : {1'b0, S2};
            S2:      mealy_step = b ? {1'b1, S0} : {1'b0, S0};
            default: mealy_step = {1'b0, S0};
        endcase
    endfunction

    state_t           state_r [NCH];
    logic [CNT_W-1:0] cnt_r   [NCH];
    logic [CW-1:0]    ptr_r;
    logic [NCH-1:0]   det_out_r;
    logic             match_valid_r;
    logic [CW-1:0]    match_ch_r;

    logic [NCH-1:0]   eligible_s;
    logic             found_s;
    logic [CW-1:0]    grant_idx_s;
    logic [CW-1:0]    cand_s;
    logic [NCH-1:0]   grant_s;
    logic [2:0]       step_s;
    logic             hit_s;

    assign eligible_s = bit_valid & ch_en;

    // Round-robin search starting at the pointer, wrapping modulo NCH.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {CW{1'b0}};
        cand_s      = {CW{1'b0}};
        for (int j = 0; j < NCH; j++) begin
            cand_s = ptr_r + CW'(j);
            if (!found_s && eligible_s[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Grant decode and detector step for the granted channel.
    always_comb begin
        grant_s = {NCH{1'b0}};
        if (found_s && !R) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NCH{1'b0}};
        end
        step_s = mealy_step(state_r[grant_idx_s], bit_in[grant_idx_s]);
        hit_s  = found_s & !R & step_s[2];
    end

    assign bit_ready   = grant_s;
    assign det_out     = det_out_r;
    assign match_valid = match_valid_r;
    assign match_ch    = match_ch_r;
    assign rd_cnt      = cnt_r[rd_ch];

    // Context store, pointer, registered match pulse and counters.
    always_ff @(posedge clk) begin
        if (R) begin
            ptr_r         <= {CW{1'b0}};
            det_out_r     <= {NCH{1'b0}};
            match_valid_r <= 1'b0;
            match_ch_r    <= {CW{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= S0;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            if (found_s) begin
                ptr_r <= grant_idx_s + CW'(1);
            end
            det_out_r     <= hit_s ? grant_s : {NCH{1'b0}};
            match_valid_r <= hit_s;
            match_ch_r    <= hit_s ? grant_idx_s : {CW{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                // A disabled channel forgets any partial pattern.
                if (!ch_en[i]) begin
                    state_r[i] <= S0;
                end else if (found_s && (grant_idx_s == CW'(i))) begin
                    state_r[i] <= state_t'(step_s[1:0]);
                end
                if (cnt_clr) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (hit_s && (grant_idx_s == CW'(i)) && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Directed self-checking bench for seqdet_rr_sched (NCH=4, CNT_W=8).
module tb_seqdet_rr_sched;

    logic       clk = 1'b0;
    logic       R;
    logic [3:0] ch_en, bit_valid, bit_in, bit_ready, det_out;
    logic       match_valid, cnt_clr;
    logic [1:0] match_ch, rd_ch;
    logic [7:0] rd_cnt;

    int total = 0;
    int bad   = 0;

    seqdet_rr_sched #(.NCH(4), .CNT_W(8)) dut (
        .clk(clk), .R(R), .ch_en(ch_en), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .det_out(det_out), .match_valid(match_valid),
        .match_ch(match_ch), .cnt_clr(cnt_clr), .rd_ch(rd_ch), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit on a single channel, expect its grant, clock it, check the pulse.
    task automatic send(input int ch, input logic b, input logic exp_det);
        logic [3:0] oh;
        oh        = 4'b0001 << ch;
        bit_valid = oh;
        bit_in    = b ? oh : 4'b0000;
        #1;
        check("send_grant", bit_ready, oh);
        tick();
        bit_valid = 4'b0000;
        check("send_det", det_out, exp_det ? oh : 4'b0000);
        check("send_mv", match_valid, exp_det);
        check("send_mch", match_ch, exp_det ? ch[1:0] : 2'd0);
    endtask

    initial begin
        R = 1'b1; ch_en = 4'b1111; bit_valid = 4'b1111; bit_in = 4'b1111;
        cnt_clr = 1'b0; rd_ch = 2'd0;
        #1;
        check("rst_ready", bit_ready, 4'b0000);
        tick();
        check("rst_det", det_out, 4'b0000);
        check("rst_mv", match_valid, 1'b0);
        check("rst_mch", match_ch, 2'd0);
        check("rst_cnt", rd_cnt, 8'd0);
        R = 1'b0; bit_valid = 4'b0000; bit_in = 4'b0000;

        // 1: ch0 101
        ch_en = 4'b0001;
        send(0, 1'b1, 1'b0); send(0, 1'b0, 1'b0); send(0, 1'b1, 1'b1);
        rd_ch = 2'd0; #1;
        check("t1_cnt", rd_cnt, 8'd1);
        tick();
        check("t1_det_drop", det_out, 4'b0000);
        check("t1_mv_drop", match_valid, 1'b0);

        // 2: ch1 10101 then 1101 -> two matches
        ch_en = 4'b0010;
        send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0); send(1, 1'b1, 1'b1);
        send(1, 1'b0, 1'b0); send(1, 1'b1, 1'b0);
        send(1, 1'b1, 1'b0); send(1, 1'b1, 1'b0); send(1, 1'b0, 1'b0); send(1, 1'b1, 1'b1);
        rd_ch = 2'd1; #1;
        check("t2_cnt", rd_cnt, 8'd2);

        // 3: reset pointer, then all channels valid with interleaved 1,0,1
        R = 1'b1; tick(); R = 1'b0;
        ch_en = 4'b1111; bit_valid = 4'b1111;
        for (int t = 0; t < 13; t++) begin
            bit_in = (t / 4 == 1 || t >= 12) ? 4'b0000 : 4'b1111;
            #1;
            check("t3_grant", bit_ready, 4'b0001 << (t % 4));
            tick();
            check("t3_det", det_out, (t / 4 == 2) ? (4'b0001 << (t % 4)) : 4'b0000);
            check("t3_mch", match_ch, (t / 4 == 2) ? 2'(t % 4) : 2'd0);
        end
        bit_valid = 4'b0000;
        rd_ch = 2'd3; #1;
        check("t3_cnt3", rd_cnt, 8'd1);

        // 4: ch2 saturation (starts at 1), then clear coincident with a match
        ch_en = 4'b0100; rd_ch = 2'd2;
        for (int k = 0; k < 256; k++) begin
            send(2, 1'b1, 1'b0); send(2, 1'b0, 1'b0); send(2, 1'b1, 1'b1);
            if (k == 253) check("t4_cnt255", rd_cnt, 8'd255);
        end
        check("t4_sat", rd_cnt, 8'd255);
        send(2, 1'b1, 1'b0); send(2, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        send(2, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("t4_clr", rd_cnt, 8'd0);

        // 5a: ch3 partial pattern dropped by ch_en low
        ch_en = 4'b1000; rd_ch = 2'd3;
        send(3, 1'b1, 1'b0); send(3, 1'b0, 1'b0);
        ch_en = 4'b0000; tick();
        ch_en = 4'b1000;
        send(3, 1'b1, 1'b0);
        send(3, 1'b0, 1'b0); send(3, 1'b1, 1'b1);
        check("t5_cnt3", rd_cnt, 8'd1);

        // 5b: reset after 1,0 on ch0
        ch_en = 4'b0001;
        send(0, 1'b1, 1'b0); send(0, 1'b0, 1'b0);
        R = 1'b1; bit_valid = 4'b0001; bit_in = 4'b0001;
        #1;
        check("t5_rst_ready", bit_ready, 4'b0000);
        tick();
        check("t5_rst_det", det_out, 4'b0000);
        check("t5_rst_mv", match_valid, 1'b0);
        check("t5_rst_cnt", rd_cnt, 8'd0);
        R = 1'b0; bit_valid = 4'b0000;
        send(0, 1'b1, 1'b0);

        // 6: nothing enabled -> no grant, pointer (1) held
        ch_en = 4'b0000; bit_valid = 4'b1111; bit_in = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_idle", bit_ready, 4'b0000);
            tick();
        end
        ch_en = 4'b1111; #1;
        check("t6_ptr", bit_ready, 4'b0010);
        ch_en = 4'b0100; #1;
        check("t6_ch2", bit_ready, 4'b0100);
        tick();
        check("t6_nodet", det_out, 4'b0000);
        bit_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seqdet_rr_sched.md
Name: seqdet_rr_sched

Overview:
- Time-multiplexed "101" serial sequence detector shared among NCH independent serial input channels.
- A round-robin scheduler grants at most one channel per cycle. For the granted channel it:
  - loads that channel's saved detector state,
  - applies the non-overlapping 101 Mealy transition,
  - writes the state back.
- Reports per-channel match pulses and keeps saturating match counters.
- Sits between the serial front-ends and the event/status logic.

Parameters:
- NCH, 4, number of channels; power of two, >= 2
- CW, $clog2(NCH), channel index width (derived; do not override)
- CNT_W, 8, per-channel match counter width

Ports:
- clk  input  1  clock, all logic on rising edge
- R  input  1  synchronous, active-high reset
- ch_en  input  NCH  per-channel enable; a disabled channel is never granted and its state is held at S0
- bit_valid  input  NCH  channel i presents a bit on bit_in[i]
- bit_in  input  NCH  serial data bit per channel
- bit_ready  output  NCH  one-hot grant, combinational; a transfer happens when bit_valid[i] & bit_ready[i]
- det_out  output  NCH  registered one-cycle match pulse per channel
- match_valid  output  1  registered; high when any det_out bit is high
- match_ch  output  CW  registered index of the matching channel; valid only while match_valid is high
- cnt_clr  input  1  synchronous clear of all match counters
- rd_ch  input  CW  counter read select
- rd_cnt  output  CNT_W  combinational read of the match counter for channel rd_ch

Behaviour:
- Reset (R=1 at a clock edge), regardless of other inputs:
  - all channel states go to S0; rr pointer goes to 0;
  - det_out=0, match_valid=0, match_ch=0;
  - all counters go to 0.
- bit_ready is forced to 0 while R=1.
- Arbitration:
  - eligible[i] = bit_valid[i] & ch_en[i].
  - Search starts at rr pointer p and wraps modulo NCH. The first eligible channel k is granted: bit_ready = one-hot(k).
  - After a grant, p <= (k+1) mod NCH. With no eligible channel, bit_ready=0 and p is unchanged.
- Handshake:
  - A source holds bit_valid and bit_in stable until it sees bit_ready high.
  - Exactly one bit is consumed per grant.
  - Sources must not depend on bit_ready to drive bit_valid (no combinational loop).
- Per-channel state is 2 bits; S0=00, S1=01, S2=10. Transitions for the granted channel k, with bit b = bit_in[k]:
  - S0: b=1 -> S1; b=0 -> S0; match=0
  - S1: b=0 -> S2; b=1 -> S1; match=0
  - S2: b=1 -> S0 with match=1; b=0 -> S0 with match=0
  - Encoding 11 (illegal) -> S0, match=0
- Non-overlapping detection: "10101" yields exactly one match; "1101" yields one match.
- Channels that are not granted keep their state unchanged.
- Latency and outputs:
  - A match from the bit accepted at edge n appears on det_out[k], match_valid=1 and match_ch=k during the cycle after edge n.
  - These are one-cycle pulses; otherwise det_out=0 and match_valid=0.
  - At most one det_out bit is high in any cycle.
- Counters:
  - On a match, cnt[k] increments and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets all counters to 0 and wins over a same-cycle increment; det_out still pulses.
  - rd_cnt reflects the register value: an increment is visible the cycle after the accepting edge.
- ch_en[i]=0:
  - state[i] <= S0 every cycle; the counter is retained.
  - Deasserting ch_en mid-sequence discards the partial pattern. Re-enabling starts from S0.
- Reset mid-operation discards all partial patterns and counts. No det_out pulse is produced for a bit presented during reset.

Test Plan:
1. ch0 only enabled, bits 1,0,1 with valid continuous -> grants on 3 consecutive cycles; det_out=0001, match_ch=0, match_valid=1 for exactly one cycle, one cycle after the third grant; rd_ch=0 gives rd_cnt=1.
2. ch1 streams 1,0,1,0,1 then 1,1,0,1 -> exactly 2 det_out[1] pulses total (non-overlap plus S1 self-loop); cnt[1]=2.
3. All 4 channels valid continuously -> bit_ready sequence 0001,0010,0100,1000,0001; each channel is fed an interleaved 1,0,1; each det_out[i] pulses once, in channel order, matching per-channel context preservation.
4. ch2 fed 256 patterns of 101 with CNT_W=8 -> rd_cnt=255 (saturated); then cnt_clr coincident with a match -> det_out[2] pulses and rd_cnt=0 the next cycle.
5. ch3 receives 1,0 then ch_en[3]=0 for one cycle, then re-enabled and fed 1 -> no match, state=S1. Separately, R asserted after 1,0 on ch0 then bit 1 -> no match, and all outputs and counters are 0 during reset.
6. ch_en=0000 with bit_valid=1111 -> bit_ready stays 0000 and the rr pointer is unchanged; re-enabling ch2 alone -> first grant 0100.
